vga_line_fetch: RTL and testbench
=================================

# vga_line_fetch

Line-buffer filler upstream of the VGA scan-out driver. On each line request from the driver it reads one display line of RGB565 pixels from SDRAM in fixed-length bursts and writes them into line buffer A or B. The driver reads the other buffer on its pixel clock. The block runs entirely on `sys_clk` and brings the driver's request across from the VGA clock domain.

## Interface
Parameters:
- `BURST_LEN`, 64: words per SDRAM burst; power of two; must divide 640 and 1024.
- `ADDR_W`, 24: SDRAM word-address width.

Ports:
- `sys_clk`  in  1  system clock; the only clock.
- `sys_rst`  in  1  synchronous, active-high reset.
- `vga_mode`  in  2  bit 1 = 1 selects 1024-word lines, otherwise 640-word lines; quasi-static.
- `read_line_req`  in  1  driver request level, VGA clock domain; held high for a whole active line.
- `read_line_A_B`  in  1  target buffer: 0 = A, 1 = B; stable while the request is high.
- `read_line_addr`  in  16  line number to fetch; stable while the request is high.
- `mem_rd_req`  out  1  burst read request; held until acknowledged.
- `mem_addr`  out  ADDR_W  burst start word address.
- `mem_rd_ack`  in  1  one-cycle acceptance of `mem_rd_req`.
- `mem_rd_valid`  in  1  read data word valid.
- `mem_rd_data`  in  16  read data word.
- `buf_wr_en`  out  1  line buffer write strobe.
- `buf_wr_sel`  out  1  0 = buffer A, 1 = buffer B.
- `buf_wr_addr`  out  10  pixel index within the line.
- `buf_wr_data`  out  16  pixel.
- `busy`  out  1  fetch or drain in progress.
- `late_cnt`  out  8  saturating count of aborted (late) lines.

## Operation
- `read_line_req` passes through a 2-flop synchronizer, then a rising/falling edge detector.
- On a rising edge, capture the following into working registers:
  - `line = read_line_addr`
  - `sel = read_line_A_B`
  - `words = vga_mode[1] ? 1024 : 640`
- Line base address is `{line[13:0], 10'b0}`, zero-extended to ADDR_W. The line stride is 1024 words. Line bits 15:14 are ignored, so line 0xFFFF maps to 0xFFFC00.
- States:
  - IDLE: on a rising edge, go to REQ.
  - REQ: assert `mem_rd_req` with `mem_addr = base + word_idx`. On `mem_rd_ack`, deassert it and go to DATA.
  - DATA: each `mem_rd_valid` writes one word and increments `word_idx`. After BURST_LEN words:
    - if `word_idx == words`, go to IDLE;
    - else go to REQ.
  - ABORT: drain the remainder of the current burst without writing, then go to IDLE (or straight to REQ if a start is pending).
- A synchronized falling edge while in REQ or DATA means the line ended before the fetch completed:
  - in REQ with `mem_rd_req` not yet acknowledged: drop the request and go to IDLE;
  - in DATA: go to ABORT;
  - either way, increment `late_cnt`, saturating at 255.
- A rising edge arriving during ABORT is latched as pending. It is captured and started after the drain. No other state can see a rising edge.
- `mem_rd_valid` outside DATA/ABORT is ignored.
- `busy` is 1 in every state except IDLE.

## Timing
- Reset values:
  - `mem_rd_req`, `mem_addr`, `buf_wr_en`, `buf_wr_sel`, `buf_wr_addr`, `buf_wr_data`, `busy`, `late_cnt`: 0.
  - State: IDLE; pending flag cleared.
- Reset mid-burst abandons the burst immediately with no drain. The system resets the SDRAM controller together with this block.
- Request latency: `read_line_req` rising at the `sys_clk` edge n is sampled at n+1, synchronized at n+2, edge detected at n+3. `mem_rd_req` is high from n+4.
- `mem_rd_req` and `mem_addr` are registered and held stable until the cycle after `mem_rd_ack`.
- Buffer writes are registered: `mem_rd_valid` at cycle k gives `buf_wr_en` = 1 at k+1, with `buf_wr_addr` = word index (0..words-1) and `buf_wr_data` = the captured data.
- `buf_wr_addr` never exceeds `words-1`.
- The final write of a line and the return of `busy` to 0 both occur in the same cycle.
- Word index width: 11 bits, so 1024 is representable. `buf_wr_addr` is bits [9:0] of the index.
- A falling edge in the same cycle as the last valid word of the line counts as a completed fetch: write the word and do not increment `late_cnt`.

## Structure
- Package `vga_fetch_pkg` holds:
  - the state enum (IDLE, REQ, DATA, ABORT);
  - `LINE_WORDS_640` = 640 and `LINE_WORDS_1024` = 1024;
  - `LINE_STRIDE_LOG2` = 10.
- Sub-module `req_sync_edge`: 2-flop synchronizer plus registered rise/fall pulses. It is reused for other cross-domain strobes.

## Test plan
- Mode 00, line 5, sel = 1, ack after 3 cycles:
  - bursts at addresses 0x1400, 0x1440 … 0x1640;
  - 640 writes to B at addresses 0..639;
  - `late_cnt` = 0.
- Mode 1x, line 0xFFFF, sel = 0: 16 bursts starting at 0xFFFC00; 1024 writes to A; the last `buf_wr_addr` is 1023.
- Request dropped after 100 words of a 640 line: the remaining 28 words of that burst are drained with no write; `late_cnt` = 1; the block returns to IDLE.
- New rise during ABORT drain for line 7: after the drain the next request is at 0x1C00; no writes are lost or duplicated.
- `sys_rst` high mid-DATA: the next cycle shows all outputs 0 and IDLE; a subsequent request for line 2 starts cleanly at 0x0800.
- 256 late lines: `late_cnt` saturates at 255.

Source files
------------

// File: rtl/vga_fetch_pkg.sv
// Shared types and constants for the VGA line fetcher.
package vga_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DATA  = 2'd2,
    ABORT = 2'd3
  } state_t;

  localparam logic [10:0] LINE_WORDS_640  = 11'd640;
  localparam logic [10:0] LINE_WORDS_1024 = 11'd1024;
  localparam int          LINE_STRIDE_LOG2 = 10;

  // Lines sit on a fixed 1024-word stride; the top two line bits are dropped.
  function automatic logic [23:0] line_base(input logic [13:0] line);
    return {line, {LINE_STRIDE_LOG2{1'b0}}};
  endfunction

endpackage

// File: rtl/req_sync_edge.sv
// Two-flop synchronizer for a slow level from another clock domain,
// followed by registered one-cycle rise and fall pulses.
module req_sync_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic r_rise;
  logic r_fall;

  // Synchronize, then compare against the previous synchronized value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_rise <= r_sync & ~r_prev;
      r_fall <= ~r_sync & r_prev;
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/vga_line_fetch.sv
// Fills one VGA line buffer (A or B) from SDRAM in fixed-length bursts
// whenever the scan-out driver raises its line request.
module vga_line_fetch
  import vga_fetch_pkg::*;
#(
  parameter int BURST_LEN = 64,
  parameter int ADDR_W    = 24
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [1:0]        vga_mode,
  input  logic              read_line_req,
  input  logic              read_line_A_B,
  input  logic [15:0]       read_line_addr,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rd_ack,
  input  logic              mem_rd_valid,
  input  logic [15:0]       mem_rd_data,
  output logic              buf_wr_en,
  output logic              buf_wr_sel,
  output logic [9:0]        buf_wr_addr,
  output logic [15:0]       buf_wr_data,
  output logic              busy,
  output logic [7:0]        late_cnt
);

  localparam int              BC_W       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BC_W-1:0] BURST_LAST = BC_W'(BURST_LEN - 1);

  state_t            r_state;
  logic [13:0]       r_line;
  logic              r_sel;
  logic [10:0]       r_words;
  logic [10:0]       r_word_idx;
  logic [BC_W-1:0]   r_burst_cnt;
  logic              r_pend;
  logic              r_rd_req;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wr_en;
  logic              r_wr_sel;
  logic [9:0]        r_wr_addr;
  logic [15:0]       r_wr_data;
  logic              r_busy;
  logic [7:0]        r_late;

  logic              w_rise;
  logic              w_fall;
  logic              w_burst_end;
  logic              w_line_done;
  logic [10:0]       w_next_idx;
  logic [ADDR_W-1:0] w_cur_base;
  logic [ADDR_W-1:0] w_new_base;
  logic [10:0]       w_new_words;
  logic [7:0]        w_late_inc;
  logic              w_unused;

  req_sync_edge u_req_sync (
    .i_clk   (sys_clk),
    .i_rst   (sys_rst),
    .i_async (read_line_req),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  assign w_burst_end = mem_rd_valid && (r_burst_cnt == BURST_LAST);
  // Lines are whole multiples of the burst, so the line can only end on a burst end.
  assign w_line_done = w_burst_end && (w_next_idx == r_words);
  assign w_next_idx  = r_word_idx + 11'd1;
  assign w_cur_base  = ADDR_W'(line_base(r_line));
  assign w_new_base  = ADDR_W'(line_base(read_line_addr[13:0]));
  assign w_new_words = vga_mode[1] ? LINE_WORDS_1024 : LINE_WORDS_640;
  assign w_late_inc  = (r_late == 8'hFF) ? r_late : r_late + 8'd1;
  assign w_unused    = &{1'b0, vga_mode[0], read_line_addr[15:14]};

  // Fetch sequencer: request bursts, write returned words, abort on a late line end.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state     <= IDLE;
      r_line      <= '0;
      r_sel       <= 1'b0;
      r_words     <= '0;
      r_word_idx  <= '0;
      r_burst_cnt <= '0;
      r_pend      <= 1'b0;
      r_rd_req    <= 1'b0;
      r_addr      <= '0;
      r_wr_en     <= 1'b0;
      r_wr_sel    <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_busy      <= 1'b0;
      r_late      <= '0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_line      <= read_line_addr[13:0];
            r_sel       <= read_line_A_B;
            r_words     <= w_new_words;
            r_word_idx  <= '0;
            r_burst_cnt <= '0;
            r_rd_req    <= 1'b1;
            r_addr      <= w_new_base;
            r_busy      <= 1'b1;
            r_state     <= REQ;
          end
        end
        REQ: begin
          if (w_fall) begin
            // An ack in the same cycle means a burst is already on its way: drain it.
            r_rd_req <= 1'b0;
            r_late   <= w_late_inc;
            if (mem_rd_ack) begin
              r_burst_cnt <= '0;
              r_state     <= ABORT;
            end else begin
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          end else if (mem_rd_ack) begin
            r_rd_req    <= 1'b0;
            r_burst_cnt <= '0;
            r_state     <= DATA;
          end
        end
        DATA: begin
          if (w_fall && !w_line_done) begin
            // Line ended early; a word arriving with the fall is treated as drained.
            r_late <= w_late_inc;
            if (w_burst_end) begin
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end else begin
              if (mem_rd_valid) r_burst_cnt <= r_burst_cnt + 1'b1;
              r_state <= ABORT;
            end
          end else if (mem_rd_valid) begin
            r_wr_en     <= 1'b1;
            r_wr_sel    <= r_sel;
            r_wr_addr   <= r_word_idx[9:0];
            r_wr_data   <= mem_rd_data;
            r_word_idx  <= w_next_idx;
            r_burst_cnt <= r_burst_cnt + 1'b1;
            if (w_line_done) begin
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end else if (w_burst_end) begin
              r_rd_req <= 1'b1;
              r_addr   <= w_cur_base + ADDR_W'(w_next_idx);
              r_state  <= REQ;
            end
          end
        end
        ABORT: begin
          if (w_rise) r_pend <= 1'b1;
          if (mem_rd_valid) begin
            r_burst_cnt <= r_burst_cnt + 1'b1;
            if (w_burst_end) begin
              r_pend <= 1'b0;
              if (r_pend || w_rise) begin
                r_line      <= read_line_addr[13:0];
                r_sel       <= read_line_A_B;
                r_words     <= w_new_words;
                r_word_idx  <= '0;
                r_burst_cnt <= '0;
                r_rd_req    <= 1'b1;
                r_addr      <= w_new_base;
                r_state     <= REQ;
              end else begin
                r_busy  <= 1'b0;
                r_state <= IDLE;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_rd_req  = r_rd_req;
  assign mem_addr    = r_addr;
  assign buf_wr_en   = r_wr_en;
  assign buf_wr_sel  = r_wr_sel;
  assign buf_wr_addr = r_wr_addr;
  assign buf_wr_data = r_wr_data;
  assign busy        = r_busy;
  assign late_cnt    = r_late;

endmodule

// File: tb/tb_vga_line_fetch.sv
// Directed bench for vga_line_fetch: table of full-line fetches plus
// hand sequences for abort, pending restart, late-fall, reset and saturation.
module tb_vga_line_fetch;

  localparam int BURST_LEN = 64;
  localparam int ADDR_W    = 24;

  logic              sys_clk = 1'b0;
  logic              sys_rst;
  logic [1:0]        vga_mode;
  logic              read_line_req;
  logic              read_line_A_B;
  logic [15:0]       read_line_addr;
  logic              mem_rd_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_ack;
  logic              mem_rd_valid;
  logic [15:0]       mem_rd_data;
  logic              buf_wr_en;
  logic              buf_wr_sel;
  logic [9:0]        buf_wr_addr;
  logic [15:0]       buf_wr_data;
  logic              busy;
  logic [7:0]        late_cnt;

  vga_line_fetch #(.BURST_LEN(BURST_LEN), .ADDR_W(ADDR_W)) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .vga_mode       (vga_mode),
    .read_line_req  (read_line_req),
    .read_line_A_B  (read_line_A_B),
    .read_line_addr (read_line_addr),
    .mem_rd_req     (mem_rd_req),
    .mem_addr       (mem_addr),
    .mem_rd_ack     (mem_rd_ack),
    .mem_rd_valid   (mem_rd_valid),
    .mem_rd_data    (mem_rd_data),
    .buf_wr_en      (buf_wr_en),
    .buf_wr_sel     (buf_wr_sel),
    .buf_wr_addr    (buf_wr_addr),
    .buf_wr_data    (buf_wr_data),
    .busy           (busy),
    .late_cnt       (late_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic        sel;
    logic [9:0]  addr;
    logic [15:0] data;
    logic        busy;
  } wr_t;

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] line;
    logic        sel;
    int          ack;
    int          bursts;
    logic [23:0] first;
    logic [23:0] last_burst;
    int          writes;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;

  wr_t         wq[$];
  logic [23:0] bq[$];
  int          ack_dly   = 1;
  logic        stall     = 1'b0;
  int          stall_at  = 0;
  int          rsp_total = 0;
  int          rsp_st    = 0;
  int          rsp_cnt   = 0;
  int          rsp_i     = 0;
  logic [23:0] rsp_addr  = '0;

  function automatic logic [15:0] dfun(input logic [23:0] a);
    return a[15:0] ^ {a[23:16], 8'h3C};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // SDRAM model and write/burst monitor share one process so ordering is fixed.
  initial begin
    mem_rd_ack   = 1'b0;
    mem_rd_valid = 1'b0;
    mem_rd_data  = '0;
    forever begin
      @(negedge sys_clk);
      if (buf_wr_en) wq.push_back({buf_wr_sel, buf_wr_addr, buf_wr_data, busy});
      mem_rd_ack   = 1'b0;
      mem_rd_valid = 1'b0;
      if (sys_rst) begin
        rsp_st  = 0;
        rsp_cnt = 0;
      end else if (rsp_st == 0) begin
        if (mem_rd_req) begin
          if (rsp_cnt >= ack_dly) begin
            mem_rd_ack = 1'b1;
            bq.push_back(mem_addr);
            rsp_addr = mem_addr;
            rsp_i    = 0;
            rsp_cnt  = 0;
            rsp_st   = 1;
          end else rsp_cnt++;
        end else rsp_cnt = 0;
      end else if (!(stall && rsp_total == stall_at)) begin
        mem_rd_valid = 1'b1;
        mem_rd_data  = dfun(rsp_addr + 24'(rsp_i));
        rsp_i++;
        rsp_total++;
        if (rsp_i == BURST_LEN) rsp_st = 0;
      end
    end
  end

  task automatic clear_mon();
    wq.delete();
    bq.delete();
    rsp_total = 0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    for (int i = 0; i < max && busy; i++) @(negedge sys_clk);
    chk(tag, busy, 1'b0);
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic wait_total(input string tag, input int n, input int max);
    for (int i = 0; i < max && rsp_total < n; i++) @(negedge sys_clk);
    chk(tag, rsp_total, n);
  endtask

  task automatic verify_writes(input string tag, input int start, input int n,
                               input logic [23:0] base, input logic sel);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (start + i >= wq.size()) bad++;
      else begin
        wr_t w;
        w = wq[start + i];
        if (w.addr != 10'(i) || w.sel != sel || w.data != dfun(base + 24'(i))) bad++;
      end
    end
    chk(tag, bad, 0);
  endtask

  task automatic verify_bursts(input string tag, input int start, input int n,
                               input logic [23:0] base);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++)
      if (start + i >= bq.size() || bq[start + i] != base + 24'(i * BURST_LEN)) bad++;
    chk(tag, bad, 0);
  endtask

  task automatic run_line(input vec_t v, input int exp_late);
    clear_mon();
    stall          = 1'b0;
    ack_dly        = v.ack;
    vga_mode       = v.mode;
    read_line_addr = v.line;
    read_line_A_B  = v.sel;
    @(posedge sys_clk); #1 read_line_req = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1 chk("req_lat_n3", mem_rd_req, 1'b0);
    @(posedge sys_clk);
    #1 chk("req_lat_n4", mem_rd_req, 1'b1);
    chk("busy_start", busy, 1'b1);
    wait_idle("line_done_to", 4000);
    chk("n_bursts", bq.size(), v.bursts);
    chk("first_burst", bq.size() > 0 ? bq[0] : 24'hxxxxxx, v.first);
    chk("last_burst", bq.size() > 0 ? bq[bq.size()-1] : 24'hxxxxxx, v.last_burst);
    verify_bursts("burst_seq", 0, v.bursts, v.first);
    chk("n_writes", wq.size(), v.writes);
    verify_writes("write_seq", 0, v.writes, v.first, v.sel);
    chk("last_wr_addr", wq.size() > 0 ? 32'(wq[wq.size()-1].addr) : 32'hx, v.writes - 1);
    chk("busy_at_last_wr", wq.size() > 0 ? wq[wq.size()-1].busy : 1'bx, 1'b0);
    chk("late_after_line", late_cnt, exp_late);
    read_line_req = 1'b0;
    repeat (8) @(posedge sys_clk);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    vec_t v2;
    vecs[0] = '{2'b00, 16'h0005, 1'b1, 3, 10, 24'h001400, 24'h001640, 640};
    vecs[1] = '{2'b10, 16'hFFFF, 1'b0, 1, 16, 24'hFFFC00, 24'hFFFFC0, 1024};
    vecs[2] = '{2'b01, 16'h0003, 1'b0, 0, 10, 24'h000C00, 24'h000E40, 640};
    vecs[3] = '{2'b11, 16'h4002, 1'b1, 2, 16, 24'h000800, 24'h000BC0, 1024};
    v2      = '{2'b00, 16'h0002, 1'b0, 1, 10, 24'h000800, 24'h000A40, 640};

    sys_rst        = 1'b1;
    vga_mode       = 2'b00;
    read_line_req  = 1'b0;
    read_line_A_B  = 1'b0;
    read_line_addr = '0;
    repeat (3) @(negedge sys_clk);
    chk("rst_req", mem_rd_req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_late", late_cnt, 8'd0);
    chk("rst_wr", {buf_wr_en, buf_wr_sel, buf_wr_addr, buf_wr_data, mem_addr}, 0);
    sys_rst = 1'b0;
    repeat (4) @(posedge sys_clk);

    for (int i = 0; i < 4; i++) run_line(vecs[i], 0);

    // Line drops after 100 words: last 28 words of burst 2 drained unwritten.
    clear_mon();
    vga_mode = 2'b00; read_line_addr = 16'd9; read_line_A_B = 1'b0;
    ack_dly = 1; stall = 1'b1; stall_at = 100;
    @(posedge sys_clk); #1 read_line_req = 1'b1;
    wait_total("abort_100_to", 100, 500);
    repeat (3) @(negedge sys_clk);
    chk("abort_busy_pre", busy, 1'b1);
    @(posedge sys_clk); #1 read_line_req = 1'b0;
    repeat (6) @(posedge sys_clk);
    #1 stall = 1'b0;
    wait_idle("abort_idle_to", 200);
    chk("abort_total", rsp_total, 128);
    chk("abort_writes", wq.size(), 100);
    verify_writes("abort_wseq", 0, 100, 24'h002400, 1'b0);
    chk("abort_bursts", bq.size(), 2);
    chk("abort_late", late_cnt, 8'd1);
    chk("abort_req", mem_rd_req, 1'b0);

    // Rise for line 7 during the drain is held and started afterwards.
    clear_mon();
    read_line_addr = 16'd4; read_line_A_B = 1'b1;
    stall = 1'b1; stall_at = 100;
    @(posedge sys_clk); #1 read_line_req = 1'b1;
    wait_total("pend_100_to", 100, 500);
    @(posedge sys_clk); #1 read_line_req = 1'b0;
    repeat (6) @(posedge sys_clk);
    #1 read_line_addr = 16'd7; read_line_A_B = 1'b0; read_line_req = 1'b1;
    repeat (6) @(posedge sys_clk);
    #1 chk("pend_busy", busy, 1'b1);
    stall = 1'b0;
    wait_idle("pend_idle_to", 3000);
    chk("pend_writes", wq.size(), 740);
    verify_writes("pend_wseq_old", 0, 100, 24'h001000, 1'b1);
    verify_writes("pend_wseq_new", 100, 640, 24'h001C00, 1'b0);
    chk("pend_bursts", bq.size(), 12);
    chk("pend_new_addr", bq.size() > 2 ? bq[2] : 24'hxxxxxx, 24'h001C00);
    verify_bursts("pend_bseq", 2, 10, 24'h001C00);
    chk("pend_late", late_cnt, 8'd2);
    read_line_req = 1'b0;
    repeat (8) @(posedge sys_clk);

    // Fall reaches the sequencer together with the line's last word: completed.
    clear_mon();
    read_line_addr = 16'd1; read_line_A_B = 1'b1;
    stall = 1'b1; stall_at = 639;
    @(posedge sys_clk); #1 read_line_req = 1'b1;
    wait_total("lastfall_to", 639, 3000);
    repeat (2) @(negedge sys_clk);
    @(posedge sys_clk); #1 read_line_req = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1 stall = 1'b0;
    wait_idle("lastfall_idle_to", 50);
    chk("lastfall_writes", wq.size(), 640);
    verify_writes("lastfall_wseq", 0, 640, 24'h000400, 1'b1);
    chk("lastfall_late", late_cnt, 8'd2);
    repeat (6) @(posedge sys_clk);

    // Reset in the middle of a burst.
    clear_mon();
    read_line_addr = 16'd3; read_line_A_B = 1'b1;
    stall = 1'b1; stall_at = 30;
    @(posedge sys_clk); #1 read_line_req = 1'b1;
    wait_total("rst_mid_to", 30, 500);
    @(negedge sys_clk);
    sys_rst = 1'b1; read_line_req = 1'b0;
    @(negedge sys_clk);
    chk("midrst_outs", {mem_rd_req, mem_addr, buf_wr_en, buf_wr_sel, buf_wr_addr, buf_wr_data}, 0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_late", late_cnt, 8'd0);
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0; stall = 1'b0;
    repeat (6) @(posedge sys_clk);
    run_line(v2, 0);

    // 256 lines that end before the first ack.
    ack_dly = 100000;
    for (int i = 0; i < 256; i++) begin
      @(posedge sys_clk); #1 read_line_req = 1'b1;
      repeat (6) @(posedge sys_clk);
      #1 read_line_req = 1'b0;
      repeat (6) @(posedge sys_clk);
      if (i == 253) #1 chk("late_254", late_cnt, 8'd254);
      if (i == 254) #1 chk("late_255", late_cnt, 8'd255);
    end
    #1 chk("late_sat", late_cnt, 8'd255);
    chk("sat_req_low", mem_rd_req, 1'b0);
    chk("sat_idle", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
